gearbox_param: RTL and testbench
================================

GEARBOX_PARAM -- requirements
Module: gearbox_param

Interface
REQ-001 SHALL have parameter IN_W, default 66, input word width in bits (>=1).
REQ-002 SHALL have parameter OUT_W, default 40, output word width in bits (>=1).
REQ-003 SHALL have internal constants STOR_W = IN_W+OUT_W and FILL_W = clog2(STOR_W+1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 arst  input  1  reset; asynchronous, active-high.
REQ-006 sclr  input  1  synchronous clear of fill state.
REQ-007 din  input  IN_W  input word, lsbit first on the line.
REQ-008 din_valid  input  1  din holds a word.
REQ-009 din_ready  output  1  block accepts din this cycle.
REQ-010 dout  output  OUT_W  output word, lsbit first.
REQ-011 dout_valid  output  1  dout holds a complete word.
REQ-012 dout_ready  input  1  sink takes dout this cycle.
REQ-013 bitslip  input  1  request to discard one stream bit.
REQ-014 underrun  output  1  registered pulse: sink wanted data but none was available.

Function
REQ-015 SHALL hold bits in a STOR_W-bit register stor with FILL_W-bit count fill; valid bits occupy stor[fill-1:0], oldest bit at bit 0.
REQ-016 dout SHALL equal stor[OUT_W-1:0], or stor[OUT_W:1] when a slip applies (REQ-024), and dout_valid = (fill >= OUT_W + slip_now).
REQ-017 take = dout_valid & dout_ready; consumed bits per cycle = take*(OUT_W+slip_now).
REQ-018 din_ready = (fill - consumed + IN_W <= STOR_W), combinational from fill, dout_ready and slip state, independent of din_valid.
REQ-019 accept = din_valid & din_ready; accepted din SHALL be written at bit position fill-consumed after the shift right by consumed.
REQ-020 Next fill = fill - consumed + accept*IN_W; it SHALL never exceed STOR_W or go below 0.
REQ-021 Latency: a word accepted with fill < OUT_W SHALL make dout_valid high on the next cycle at the earliest.
REQ-022 With din_valid and dout_ready held high, dout_valid SHALL stay high every cycle after the first, with no bubble, for any IN_W >= OUT_W.
REQ-023 underrun SHALL be 1 on the cycle after a cycle with dout_ready=1, dout_valid=0 and fill != 0, otherwise 0.
REQ-024 A bitslip pulse SHALL set slip_pend; while slip_pend=1, slip_now=1 and the next take consumes OUT_W+1 bits and clears slip_pend; a bitslip during a pending slip SHALL be ignored.
REQ-025 sclr SHALL set fill=0, slip_pend=0 and underrun=0 at the next edge, leave stor data unchanged, and block the accept and take of that cycle (din_ready=0, dout_valid=0 while sclr=1).

Reset
REQ-026 arst SHALL immediately set fill=0, stor=0, slip_pend=0 and underrun=0, giving dout=0, dout_valid=0 and din_ready=1.
REQ-027 arst asserted mid-stream SHALL discard all held bits; the first word accepted after release SHALL occupy stor from bit 0.

Configuration
REQ-028 Macro GEARBOX_BITSLIP_EN defined: bitslip SHALL be implemented as in REQ-024.
REQ-029 Macro GEARBOX_BITSLIP_EN undefined: the bitslip port SHALL remain present but be ignored, slip_now SHALL be constant 0, and no slip_pend flop SHALL exist.

Verification
REQ-030 IN_W=66, OUT_W=40, din_valid=1, dout_ready=1 from reset, incrementing pattern -> exactly 20 accepts and 33 outputs per 33-cycle window, dout_valid continuous from cycle 1, output bitstream equals input bitstream.
REQ-031 Same config, dout_ready=0 for 5 cycles -> fill peaks at 106 with no extra accept, then resumes without bit loss.
REQ-032 Same config, din_valid=0 after 1 word (fill 66) -> 1 output, then fill 26 with dout_valid=0; with dout_ready=1, underrun=1 on the following cycle.
REQ-033 GEARBOX_BITSLIP_EN defined, bitslip pulse at steady state -> exactly one bit missing from the output stream; a second pulse while pending removes no extra bit.
REQ-034 arst mid-stream at fill=52, then sclr mid-stream at fill=92 -> dout_valid=0 and fill=0 immediately for arst and next edge for sclr; the next accepted word appears at dout[39:0] as din[39:0].
REQ-035 IN_W=OUT_W=32 -> 1:1 pass-through with one-cycle latency and full throughput.

Source files
------------

// File: rtl/gearbox_param.sv
// Bit gearbox: IN_W-bit words in, OUT_W-bit words out, lsbit first, with valid/ready on both sides.
// Define GEARBOX_BITSLIP_EN to enable the bitslip request (otherwise the port is ignored).
module gearbox_param #(
    parameter int IN_W  = 66,
    parameter int OUT_W = 40
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             sclr,
    input  logic [IN_W-1:0]  din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    input  logic             bitslip,
    output logic             underrun
);
    localparam int STOR_W = IN_W + OUT_W;
    localparam int FILL_W = $clog2(STOR_W + 1);
    localparam logic [FILL_W:0] C_IN_W   = (FILL_W+1)'(IN_W);
    localparam logic [FILL_W:0] C_OUT_W  = (FILL_W+1)'(OUT_W);
    localparam logic [FILL_W:0] C_STOR_W = (FILL_W+1)'(STOR_W);

    logic [STOR_W-1:0] r_stor;
    logic [FILL_W-1:0] r_fill;
    logic              r_underrun;

    logic              w_slip_now;
    logic [FILL_W:0]   w_need;
    logic [FILL_W:0]   w_cons;
    logic [FILL_W:0]   w_rem;
    logic              w_take;
    logic              w_accept;
    logic [STOR_W-1:0] w_shift;
    logic [STOR_W-1:0] w_mask;
    logic [STOR_W-1:0] w_data;
    logic [STOR_W-1:0] w_stor_n;
    logic [FILL_W-1:0] w_fill_n;
    logic              w_underrun_n;

`ifdef GEARBOX_BITSLIP_EN
    logic r_slip_pend;

    // A pending slip is retired by the next take; further requests meanwhile are dropped.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_slip_pend <= 1'b0;
        end else if (sclr) begin
            r_slip_pend <= 1'b0;
        end else if (r_slip_pend) begin
            r_slip_pend <= !w_take;
        end else begin
            r_slip_pend <= bitslip;
        end
    end

    assign w_slip_now = r_slip_pend;
`else
    logic w_unused_bitslip;
    assign w_unused_bitslip = bitslip;
    assign w_slip_now       = 1'b0;
`endif

    always_comb begin
        w_need     = C_OUT_W + {{FILL_W{1'b0}}, w_slip_now};
        dout_valid = !sclr && ({1'b0, r_fill} >= w_need);
        w_take     = dout_valid && dout_ready;
        w_cons     = w_take ? w_need : '0;
        w_rem      = {1'b0, r_fill} - w_cons;
        din_ready  = !sclr && ((w_rem + C_IN_W) <= C_STOR_W);
        w_accept   = din_valid && din_ready;
        dout       = w_slip_now ? r_stor[OUT_W:1] : r_stor[OUT_W-1:0];
    end

    // Shift out consumed bits, then drop the new word in just above the remaining ones.
    // Bits above fill may be stale (sclr keeps stor), so the landing slot is masked first.
    always_comb begin
        w_shift  = r_stor >> w_cons;
        w_mask   = {{OUT_W{1'b0}}, {IN_W{1'b1}}} << w_rem;
        w_data   = {{OUT_W{1'b0}}, din} << w_rem;
        w_stor_n = w_accept ? ((w_shift & ~w_mask) | w_data) : w_shift;
        w_fill_n = FILL_W'(w_rem + (w_accept ? C_IN_W : '0));
        w_underrun_n = !sclr && dout_ready && !dout_valid && (r_fill != '0);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_stor     <= '0;
            r_fill     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_stor     <= w_stor_n;
            r_fill     <= sclr ? '0 : w_fill_n;
            r_underrun <= w_underrun_n;
        end
    end

    assign underrun = r_underrun;
endmodule

// File: tb/tb_gearbox_param.sv
// Bench for gearbox_param: a 32/32 instance driven from a vector table and a 66/40 instance
// checked every cycle against a bit-queue scoreboard.
module tb_gearbox_param;
    localparam int IW = 66;
    localparam int OW = 40;
    localparam int SW = IW + OW;
`ifdef GEARBOX_BITSLIP_EN
    localparam bit SLIP_EN = 1'b1;
`else
    localparam bit SLIP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    // 66 -> 40 instance
    logic          d_sclr, d_din_valid, d_din_ready, d_dout_valid, d_dout_ready, d_bitslip, d_underrun;
    logic [IW-1:0] d_din;
    logic [OW-1:0] d_dout;

    gearbox_param #(.IN_W(IW), .OUT_W(OW)) u_dut (
        .clk(clk), .arst(arst), .sclr(d_sclr),
        .din(d_din), .din_valid(d_din_valid), .din_ready(d_din_ready),
        .dout(d_dout), .dout_valid(d_dout_valid), .dout_ready(d_dout_ready),
        .bitslip(d_bitslip), .underrun(d_underrun)
    );

    // 32 -> 32 instance
    logic        p_sclr, p_din_valid, p_din_ready, p_dout_valid, p_dout_ready, p_bitslip, p_underrun;
    logic [31:0] p_din, p_dout;

    gearbox_param #(.IN_W(32), .OUT_W(32)) u_p32 (
        .clk(clk), .arst(arst), .sclr(p_sclr),
        .din(p_din), .din_valid(p_din_valid), .din_ready(p_din_ready),
        .dout(p_dout), .dout_valid(p_dout_valid), .dout_ready(p_dout_ready),
        .bitslip(p_bitslip), .underrun(p_underrun)
    );

    typedef struct {
        logic [31:0] din;
        logic        dv;
        logic        dr;
        logic        ev;
        logic [31:0] ed;
        logic        er;
        logic        eu;
    } vec_t;

    vec_t tbl [10];

    int n_chk  = 0;
    int n_pass = 0;
    int n_acc  = 0;
    int n_out  = 0;
    bit q [$];
    bit m_und  = 1'b0;
    bit m_pend = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One cycle on the 66/40 instance: drive, compare against the bit queue, advance the model.
    task automatic cyc(input logic [IW-1:0] w, input logic dv, input logic dr,
                       input logic bs, input logic sc);
        logic          ev, er;
        logic [OW-1:0] ed;
        int            sn, cons;
        d_din = w; d_din_valid = dv; d_dout_ready = dr; d_bitslip = bs; d_sclr = sc;
        #2;
        sn   = m_pend ? 1 : 0;
        ev   = !sc && (q.size() >= OW + sn);
        cons = (ev && dr) ? OW + sn : 0;
        er   = !sc && (q.size() - cons + IW <= SW);
        chk("dout_valid", d_dout_valid, ev);
        chk("din_ready", d_din_ready, er);
        chk("underrun", d_underrun, m_und);
        if (ev) begin
            for (int i = 0; i < OW; i++) ed[i] = q[i + sn];
            chk("dout_stream", d_dout, ed);
        end
        m_und = !sc && dr && !ev && (q.size() != 0);
        if (sc) begin
            q.delete();
            m_pend = 1'b0;
        end else begin
            repeat (cons) void'(q.pop_front());
            if (cons != 0) n_out++;
            if (dv && er) begin
                for (int i = 0; i < IW; i++) q.push_back(w[i]);
                n_acc++;
            end
            if (SLIP_EN) m_pend = m_pend ? (cons == 0) : bs;
        end
        @(posedge clk); #1;
    endtask

    task automatic rst_pulse();
        arst = 1'b1;
        #1;
        q.delete();
        m_und  = 1'b0;
        m_pend = 1'b0;
        @(posedge clk); #1;
        arst = 1'b0;
    endtask

    function automatic logic [IW-1:0] word(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {kk[1:0], 32'hC0DE_0000 ^ kk, kk * 32'h9E37_79B9};
    endfunction

    initial begin
        int a0, o0;
        logic [IW-1:0] w;

        arst = 1'b1;
        d_sclr = 0; d_din = '0; d_din_valid = 0; d_dout_ready = 0; d_bitslip = 0;
        p_sclr = 0; p_din = '0; p_din_valid = 0; p_dout_ready = 0; p_bitslip = 0;
        #1;
        chk("rst_dout", d_dout, '0);
        chk("rst_dout_valid", d_dout_valid, 1'b0);
        chk("rst_din_ready", d_din_ready, 1'b1);
        chk("rst_underrun", d_underrun, 1'b0);
        chk("rst32_dout_valid", p_dout_valid, 1'b0);
        chk("rst32_din_ready", p_din_ready, 1'b1);
        @(posedge clk); #1;
        arst = 1'b0;

        // 32/32: one-cycle latency, stall and drain
        tbl[0] = '{32'hA0A0_0001, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
        tbl[1] = '{32'hB0B0_0002, 1'b1, 1'b1, 1'b1, 32'hA0A0_0001, 1'b1, 1'b0};
        tbl[2] = '{32'hC0C0_0003, 1'b1, 1'b1, 1'b1, 32'hB0B0_0002, 1'b1, 1'b0};
        tbl[3] = '{32'hD0D0_0004, 1'b1, 1'b0, 1'b1, 32'hC0C0_0003, 1'b1, 1'b0};
        tbl[4] = '{32'hE0E0_0005, 1'b1, 1'b0, 1'b1, 32'hC0C0_0003, 1'b0, 1'b0};
        tbl[5] = '{32'hE0E0_0005, 1'b1, 1'b1, 1'b1, 32'hC0C0_0003, 1'b1, 1'b0};
        tbl[6] = '{32'h0,         1'b0, 1'b1, 1'b1, 32'hD0D0_0004, 1'b1, 1'b0};
        tbl[7] = '{32'h0,         1'b0, 1'b1, 1'b1, 32'hE0E0_0005, 1'b1, 1'b0};
        tbl[8] = '{32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
        tbl[9] = '{32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            p_din = tbl[i].din; p_din_valid = tbl[i].dv; p_dout_ready = tbl[i].dr;
            #2;
            chk($sformatf("t32[%0d].dout_valid", i), p_dout_valid, tbl[i].ev);
            chk($sformatf("t32[%0d].din_ready", i), p_din_ready, tbl[i].er);
            chk($sformatf("t32[%0d].underrun", i), p_underrun, tbl[i].eu);
            if (tbl[i].ev) chk($sformatf("t32[%0d].dout", i), p_dout, tbl[i].ed);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 20; i++) begin
            p_din = 32'h5A00_1000 + 32'(i); p_din_valid = 1'b1; p_dout_ready = 1'b1;
            #2;
            chk("p32_ready", p_din_ready, 1'b1);
            if (i > 0) begin
                chk("p32_valid", p_dout_valid, 1'b1);
                chk("p32_dout", p_dout, 32'h5A00_1000 + 32'(i - 1));
            end
            @(posedge clk); #1;
        end
        p_din_valid = 1'b0;

        // 66/40: single word then starve -> underrun
        rst_pulse();
        cyc(word(7), 1, 1, 0, 0);
        cyc('0, 0, 1, 0, 0);
        chk("fill26_no_valid", d_dout_valid, 1'b0);
        cyc('0, 0, 1, 0, 0);
        chk("underrun_pulse", d_underrun, 1'b1);
        cyc('0, 0, 1, 0, 0);

        // continuous streaming, 20 accepts / 33 outputs per 33-cycle window
        rst_pulse();
        a0 = 0; o0 = 0;
        for (int k = 0; k < 70; k++) begin
            if (k == 1) begin a0 = n_acc; o0 = n_out; end
            if (k == 34) begin
                chk("accepts_per_33", n_acc - a0, 20);
                chk("outputs_per_33", n_out - o0, 33);
            end
            cyc(word(k), 1, 1, 0, 0);
        end

        // sink stall then resume
        for (int k = 0; k < 5; k++) cyc(word(100 + k), 1, 0, 0, 0);
        chk("stall_din_ready", d_din_ready, 1'b0);
        for (int k = 0; k < 20; k++) cyc(word(200 + k), 1, 1, 0, 0);

        // bitslip, then a second request while still pending
        cyc(word(300), 1, 1, 1, 0);
        cyc(word(301), 1, 0, 1, 0);
        for (int k = 0; k < 15; k++) cyc(word(310 + k), 1, 1, 0, 0);
        for (int k = 0; k < 6; k++) cyc('0, 0, 1, 0, 0);

        // async reset at fill 52, sync clear at fill 92
        rst_pulse();
        for (int k = 0; k < 20 && q.size() != 52; k++) cyc(word(400 + k), 1, 1, 0, 0);
        chk("reach_fill52", q.size(), 52);
        arst = 1'b1;
        #1;
        chk("arst_dout_valid", d_dout_valid, 1'b0);
        chk("arst_din_ready", d_din_ready, 1'b1);
        chk("arst_dout", d_dout, '0);
        q.delete(); m_und = 1'b0; m_pend = 1'b0;
        @(posedge clk); #1;
        arst = 1'b0;
        for (int k = 0; k < 20 && q.size() != 92; k++) cyc(word(500 + k), 1, 1, 0, 0);
        chk("reach_fill92", q.size(), 92);
        cyc(word(600), 1, 1, 0, 1);
        chk("sclr_empty", d_dout_valid, 1'b0);
        w = word(777);
        cyc(w, 1, 1, 0, 0);
        chk("post_sclr_valid", d_dout_valid, 1'b1);
        chk("post_sclr_dout", d_dout, w[OW-1:0]);
        for (int k = 0; k < 8; k++) cyc(word(800 + k), 1, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
